calc1_hold_ports: RTL and testbench
===================================

# calc1_hold_ports

Input holding stage of the calc1 request path, directly upstream of the priority logic. It accepts one command and two operands per requester port, validates the command, and presents a one-cycle request code to the priority stage. It then holds the operands stable for the ALUs and blocks the port until the output stage reports that the response has been delivered.

## Interface
Parameters:
- `DATA_W`, 32, operand width.
- `PORTS`, 4, number of requester ports. It is fixed at 4 because the priority stage decodes 2-bit request ids.

Ports (N = 1..4):
- `c_clk`  in  1  the block's single clock; all flops update on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `reqN_cmd_in`  in  [0:3]  command from port N; 0 means idle.
- `reqN_data_in`  in  [0:DATA_W-1]  operand bus of port N.
- `holdN_done`  in  1  response for port N delivered, from the output stage.
- `holdN_prio_req`  out  [0:3]  request code to the priority stage; non-zero for exactly one cycle per command.
- `holdN_data1`, `holdN_data2`  out  [0:DATA_W-1]  captured operands for the ALUs.
- `holdN_busy`  out  1  port N has a command in flight.
- `holdN_inv_resp`  out  1  one-cycle pulse: port N's command was illegal.
- `holdN_overrun`  out  1  sticky flag: a command arrived while the port was busy.

## Operation
- Legal commands: 1 add, 2 sub, 5 shift-left, 6 shift-right. Every other non-zero value (3, 4, 7–15) is illegal.
- Each port runs an independent FSM with states IDLE, OP2, ISSUE, INV, WAIT.
- IDLE:
  - If `cmd_in` is non-zero, capture `cmd` and `data_in` into `data1`, then go to OP2.
  - If `cmd_in` is zero, stay in IDLE.
- OP2: capture `data_in` into `data2`.
  - Legal command: go to ISSUE.
  - Illegal command: go to INV.
- ISSUE: drive `prio_req` with the captured command for this one cycle, then go to WAIT.
- INV: pulse `inv_resp` for one cycle and never drive `prio_req`, then go to IDLE.
- WAIT: hold until `done` is 1, then go to IDLE.
- `busy` = (state != IDLE).
- `prio_req` is 0 in every state except ISSUE. A command is forwarded exactly once, because the priority stage latches any non-zero code until the command is granted.
- `data1` and `data2` keep their values until the next capture; they are not cleared when the port returns to IDLE.
- `done` is acted on only in WAIT; in any other state it is ignored.
- A non-zero `cmd_in` in any state other than IDLE is dropped and sets `overrun`. This includes the cycle in which `done` is sampled in WAIT. `overrun` clears only on reset.
- Ports never interact; all four may issue in the same cycle.

## Timing
- Command plus operand 1 arrive in cycle T; operand 2 arrives in T+1.
- `busy` rises in T+1.
- T+2: `prio_req` is non-zero for exactly one cycle, and `data1`/`data2` are valid from then on.
- Illegal command: `inv_resp` is high in T+2, and `busy` falls in T+3.
- Legal command with `done` high in cycle D (D ≥ T+3): `busy` falls in D+1. A new command is accepted from D+1.
- Minimum back-to-back spacing on one port:
  - illegal command: 3 cycles;
  - legal command: 4 cycles.
- On reset assertion (asynchronous, from any state):
  - all FSMs go to IDLE;
  - `prio_req`, `data1`, `data2`, `busy`, `inv_resp` and `overrun` all go to 0.
- Reset mid-operation discards the in-flight command without any pulse.
- Reset deassertion takes effect at the first rising edge of `c_clk` after `reset` goes high.

## Structure
- Shared package `calc1_pkg` holds:
  - command codes: CMD_NONE = 0, CMD_ADD = 1, CMD_SUB = 2, CMD_SHL = 5, CMD_SHR = 6;
  - the legal-command check function;
  - the FSM state encoding;
  - `DATA_W`.
- Sub-module `calc1_hold_port` contains one port's FSM, operand registers and flags. The top level instantiates it 4 times and flattens its outputs onto the `holdN_*` ports.

## Test plan
- Add on port 1: cmd 1 with data 5 at T, data 3 at T+1 → `hold1_prio_req` = 1 only at T+2, `data1` = 5, `data2` = 3; with `done` at T+5, `busy` is high T+1..T+5.
- Illegal command on port 2: cmd 4 at T → `hold2_inv_resp` high only at T+2, `prio_req` stays 0 throughout, `busy` low at T+3.
- Overrun on port 3: cmd 6 at T, then cmd 1 at T+3 while in WAIT → second command dropped, `overrun` = 1 and stays 1 after `done`; `data1` unchanged.
- All four ports: cmds 1, 2, 5, 6 at the same T → all four `prio_req` are non-zero at T+2 with their own codes and operands.
- Port 4 in WAIT, reset pulsed low for half a cycle → all outputs 0 immediately; after release a new command at T' gives `prio_req` at T'+2.
- `done` raised on port 1 while IDLE or OP2 → ignored; the in-flight command still issues at T+2.

Source files
------------

// File: rtl/calc1_pkg.sv
// calc1_pkg
//   Shared definitions for the calc1 request path: operand width, command
//   codes, the legal-command check and the hold-port FSM state encoding.
package calc1_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] CMD_NONE = 4'd0;
    localparam logic [3:0] CMD_ADD  = 4'd1;
    localparam logic [3:0] CMD_SUB  = 4'd2;
    localparam logic [3:0] CMD_SHL  = 4'd5;
    localparam logic [3:0] CMD_SHR  = 4'd6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OP2   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_INV   = 3'd3,
        ST_WAIT  = 3'd4
    } hold_state_t;

    // Only the four ALU operations are forwarded; everything else non-zero
    // is answered with an invalid-response pulse.
    function automatic logic is_legal_cmd(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
               (cmd == CMD_SHL) || (cmd == CMD_SHR);
    endfunction

endpackage

// File: rtl/calc1_hold_port.sv
// calc1_hold_port
//   One requester port of the hold stage: captures command + two operands
//   on consecutive cycles, issues a one-cycle request code (or an invalid
//   pulse), then holds operands and busy until the response is delivered.
// Ports:
//   c_clk, reset  clock, async active-low reset
//   cmd_in        command, 0 = idle
//   data_in       operand bus (op1 with the command, op2 the cycle after)
//   done          response delivered (acted on only while waiting)
//   prio_req      request code, non-zero for exactly one cycle per command
//   data1, data2  captured operands, kept until the next capture
//   busy          command in flight
//   inv_resp      one-cycle pulse for an illegal command
//   overrun       sticky: a command arrived while busy
module calc1_hold_port #(
    parameter int DATA_W = calc1_pkg::DATA_W
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        cmd_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              done,
    output logic [3:0]        prio_req,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic              busy,
    output logic              inv_resp,
    output logic              overrun
);
    import calc1_pkg::*;

    hold_state_t state;
    logic [3:0]  cmd_q;

    // All outputs are registered; busy is updated alongside every state
    // change so it always equals (state != ST_IDLE).
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cmd_q    <= CMD_NONE;
            prio_req <= CMD_NONE;
            data1    <= '0;
            data2    <= '0;
            busy     <= 1'b0;
            inv_resp <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            prio_req <= CMD_NONE;
            inv_resp <= 1'b0;

            // Anything arriving outside IDLE is dropped, including the
            // cycle in which done releases WAIT.
            if (state != ST_IDLE && cmd_in != CMD_NONE)
                overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (cmd_in != CMD_NONE) begin
                        cmd_q <= cmd_in;
                        data1 <= data_in;
                        busy  <= 1'b1;
                        state <= ST_OP2;
                    end
                end
                ST_OP2: begin
                    data2 <= data_in;
                    if (is_legal_cmd(cmd_q)) begin
                        prio_req <= cmd_q;   // visible only while in ISSUE
                        state    <= ST_ISSUE;
                    end else begin
                        inv_resp <= 1'b1;    // visible only while in INV
                        state    <= ST_INV;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_INV: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                ST_WAIT: begin
                    if (done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/calc1_hold_ports.sv
// calc1_hold_ports
//   Input holding stage of the calc1 request path: four independent
//   calc1_hold_port instances, flattened onto per-port holdN_* outputs.
// Ports (N = 1..4):
//   c_clk, reset                     clock, async active-low reset
//   reqN_cmd_in, reqN_data_in        command and operand bus of port N
//   holdN_done                       response delivered for port N
//   holdN_prio_req                   one-cycle request code to priority stage
//   holdN_data1, holdN_data2         captured operands for the ALUs
//   holdN_busy, holdN_inv_resp,
//   holdN_overrun                    per-port status flags
module calc1_hold_ports #(
    parameter int DATA_W = calc1_pkg::DATA_W,
    // Fixed: the priority stage decodes 2-bit request ids.
    parameter int PORTS  = 4
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req1_cmd_in,
    input  logic [DATA_W-1:0] req1_data_in,
    input  logic [3:0]        req2_cmd_in,
    input  logic [DATA_W-1:0] req2_data_in,
    input  logic [3:0]        req3_cmd_in,
    input  logic [DATA_W-1:0] req3_data_in,
    input  logic [3:0]        req4_cmd_in,
    input  logic [DATA_W-1:0] req4_data_in,
    input  logic              hold1_done,
    input  logic              hold2_done,
    input  logic              hold3_done,
    input  logic              hold4_done,
    output logic [3:0]        hold1_prio_req,
    output logic [DATA_W-1:0] hold1_data1,
    output logic [DATA_W-1:0] hold1_data2,
    output logic              hold1_busy,
    output logic              hold1_inv_resp,
    output logic              hold1_overrun,
    output logic [3:0]        hold2_prio_req,
    output logic [DATA_W-1:0] hold2_data1,
    output logic [DATA_W-1:0] hold2_data2,
    output logic              hold2_busy,
    output logic              hold2_inv_resp,
    output logic              hold2_overrun,
    output logic [3:0]        hold3_prio_req,
    output logic [DATA_W-1:0] hold3_data1,
    output logic [DATA_W-1:0] hold3_data2,
    output logic              hold3_busy,
    output logic              hold3_inv_resp,
    output logic              hold3_overrun,
    output logic [3:0]        hold4_prio_req,
    output logic [DATA_W-1:0] hold4_data1,
    output logic [DATA_W-1:0] hold4_data2,
    output logic              hold4_busy,
    output logic              hold4_inv_resp,
    output logic              hold4_overrun
);

    logic [PORTS-1:0][3:0]        cmd;
    logic [PORTS-1:0][DATA_W-1:0] din;
    logic [PORTS-1:0]             done;
    logic [PORTS-1:0][3:0]        prio;
    logic [PORTS-1:0][DATA_W-1:0] d1;
    logic [PORTS-1:0][DATA_W-1:0] d2;
    logic [PORTS-1:0]             busy;
    logic [PORTS-1:0]             inv;
    logic [PORTS-1:0]             ovr;

    assign cmd  = {req4_cmd_in,  req3_cmd_in,  req2_cmd_in,  req1_cmd_in};
    assign din  = {req4_data_in, req3_data_in, req2_data_in, req1_data_in};
    assign done = {hold4_done,   hold3_done,   hold2_done,   hold1_done};

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        calc1_hold_port #(.DATA_W(DATA_W)) u_port (
            .c_clk    (c_clk),
            .reset    (reset),
            .cmd_in   (cmd[p]),
            .data_in  (din[p]),
            .done     (done[p]),
            .prio_req (prio[p]),
            .data1    (d1[p]),
            .data2    (d2[p]),
            .busy     (busy[p]),
            .inv_resp (inv[p]),
            .overrun  (ovr[p])
        );
    end

    assign hold1_prio_req = prio[0];
    assign hold1_data1    = d1[0];
    assign hold1_data2    = d2[0];
    assign hold1_busy     = busy[0];
    assign hold1_inv_resp = inv[0];
    assign hold1_overrun  = ovr[0];

    assign hold2_prio_req = prio[1];
    assign hold2_data1    = d1[1];
    assign hold2_data2    = d2[1];
    assign hold2_busy     = busy[1];
    assign hold2_inv_resp = inv[1];
    assign hold2_overrun  = ovr[1];

    assign hold3_prio_req = prio[2];
    assign hold3_data1    = d1[2];
    assign hold3_data2    = d2[2];
    assign hold3_busy     = busy[2];
    assign hold3_inv_resp = inv[2];
    assign hold3_overrun  = ovr[2];

    assign hold4_prio_req = prio[3];
    assign hold4_data1    = d1[3];
    assign hold4_data2    = d2[3];
    assign hold4_busy     = busy[3];
    assign hold4_inv_resp = inv[3];
    assign hold4_overrun  = ovr[3];

endmodule

// File: tb/tb_calc1_hold_ports.sv
// tb_calc1_hold_ports
//   Self-checking bench for calc1_hold_ports: a directed vector table on
//   port 1, hand-written multi-cycle sequences (all ports, overrun, reset
//   mid-WAIT), then randomized traffic against a cycle-numbered
//   transaction model.
module tb_calc1_hold_ports;

    logic        c_clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  cmd  [4];
    logic [31:0] din  [4];
    logic        done [4];
    logic [3:0]  prio [4];
    logic [31:0] d1   [4];
    logic [31:0] d2   [4];
    logic        busy [4];
    logic        inv  [4];
    logic        ovr  [4];

    int checks = 0;
    int errors = 0;

    always #5 c_clk = ~c_clk;

    calc1_hold_ports dut (
        .c_clk(c_clk), .reset(reset),
        .req1_cmd_in(cmd[0]), .req1_data_in(din[0]),
        .req2_cmd_in(cmd[1]), .req2_data_in(din[1]),
        .req3_cmd_in(cmd[2]), .req3_data_in(din[2]),
        .req4_cmd_in(cmd[3]), .req4_data_in(din[3]),
        .hold1_done(done[0]), .hold2_done(done[1]),
        .hold3_done(done[2]), .hold4_done(done[3]),
        .hold1_prio_req(prio[0]), .hold1_data1(d1[0]), .hold1_data2(d2[0]),
        .hold1_busy(busy[0]), .hold1_inv_resp(inv[0]), .hold1_overrun(ovr[0]),
        .hold2_prio_req(prio[1]), .hold2_data1(d1[1]), .hold2_data2(d2[1]),
        .hold2_busy(busy[1]), .hold2_inv_resp(inv[1]), .hold2_overrun(ovr[1]),
        .hold3_prio_req(prio[2]), .hold3_data1(d1[2]), .hold3_data2(d2[2]),
        .hold3_busy(busy[2]), .hold3_inv_resp(inv[2]), .hold3_overrun(ovr[2]),
        .hold4_prio_req(prio[3]), .hold4_data1(d1[3]), .hold4_data2(d2[3]),
        .hold4_busy(busy[3]), .hold4_inv_resp(inv[3]), .hold4_overrun(ovr[3])
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] data;
        logic        done;
        logic [3:0]  prio;
        logic        busy;
        logic        inv;
        logic [31:0] d1;
        logic [31:0] d2;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(logic [3:0] c, logic [31:0] dt, logic dn,
                                logic [3:0] pr, logic b, logic iv,
                                logic [31:0] e1, logic [31:0] e2);
        vec_t v;
        v.cmd = c; v.data = dt; v.done = dn;
        v.prio = pr; v.busy = b; v.inv = iv; v.d1 = e1; v.d2 = e2;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_port(string tag, int p, logic [3:0] epr, logic eb,
                            logic ei, logic eo, logic [31:0] e1, logic [31:0] e2);
        chk($sformatf("%s p%0d prio_req", tag, p + 1), {28'd0, prio[p]}, {28'd0, epr});
        chk($sformatf("%s p%0d busy", tag, p + 1), {31'd0, busy[p]}, {31'd0, eb});
        chk($sformatf("%s p%0d inv_resp", tag, p + 1), {31'd0, inv[p]}, {31'd0, ei});
        chk($sformatf("%s p%0d overrun", tag, p + 1), {31'd0, ovr[p]}, {31'd0, eo});
        chk($sformatf("%s p%0d data1", tag, p + 1), d1[p], e1);
        chk($sformatf("%s p%0d data2", tag, p + 1), d2[p], e2);
    endtask

    task automatic clr_inputs();
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0; din[p] = 32'd0; done[p] = 1'b0;
        end
    endtask

    // Advance into the next cycle and drive that cycle's inputs.
    task automatic next_cycle();
        @(posedge c_clk);
        #1;
        clr_inputs();
    endtask

    function automatic logic legal(logic [3:0] c);
        return c inside {4'd1, 4'd2, 4'd5, 4'd6};
    endfunction

    // Reference model: each port remembers the cycle its last command was
    // accepted and the cycle it became free again (-1 while unknown).
    int          m_acc  [4];
    bit          m_act  [4];
    bit          m_lg   [4];
    int          m_fin  [4];
    logic [3:0]  m_cmd  [4];
    logic [31:0] m_d1   [4];
    logic [31:0] m_d2   [4];
    bit          m_ovr  [4];

    initial begin
        clr_inputs();

        // Reset state
        repeat (2) @(posedge c_clk);
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) chk_port("reset", p, 4'd0, 0, 0, 0, 32'd0, 32'd0);
        reset = 1'b1;

        // Directed table on port 1: add with done in OP2 ignored, illegal
        // with done in IDLE ignored, shift-left with boundary operands and
        // done in ISSUE ignored, earliest legal done at T+3.
        tbl[0]  = mk(4'd1, 32'd5, 0, 4'd0, 0, 0, 32'd0, 32'd0);
        tbl[1]  = mk(4'd0, 32'd3, 1, 4'd0, 1, 0, 32'd5, 32'd0);
        tbl[2]  = mk(4'd0, 32'd0, 0, 4'd1, 1, 0, 32'd5, 32'd3);
        tbl[3]  = mk(4'd0, 32'd0, 0, 4'd0, 1, 0, 32'd5, 32'd3);
        tbl[4]  = mk(4'd0, 32'd0, 0, 4'd0, 1, 0, 32'd5, 32'd3);
        tbl[5]  = mk(4'd0, 32'd0, 1, 4'd0, 1, 0, 32'd5, 32'd3);
        tbl[6]  = mk(4'd0, 32'd0, 0, 4'd0, 0, 0, 32'd5, 32'd3);
        tbl[7]  = mk(4'd4, 32'd9, 1, 4'd0, 0, 0, 32'd5, 32'd3);
        tbl[8]  = mk(4'd0, 32'd7, 0, 4'd0, 1, 0, 32'd9, 32'd3);
        tbl[9]  = mk(4'd0, 32'd0, 0, 4'd0, 1, 1, 32'd9, 32'd7);
        tbl[10] = mk(4'd0, 32'd0, 0, 4'd0, 0, 0, 32'd9, 32'd7);
        tbl[11] = mk(4'd5, 32'hFFFF_FFFF, 0, 4'd0, 0, 0, 32'd9, 32'd7);
        tbl[12] = mk(4'd0, 32'h8000_0000, 0, 4'd0, 1, 0, 32'hFFFF_FFFF, 32'd7);
        tbl[13] = mk(4'd0, 32'd0, 1, 4'd5, 1, 0, 32'hFFFF_FFFF, 32'h8000_0000);
        tbl[14] = mk(4'd0, 32'd0, 1, 4'd0, 1, 0, 32'hFFFF_FFFF, 32'h8000_0000);
        tbl[15] = mk(4'd0, 32'd0, 0, 4'd0, 0, 0, 32'hFFFF_FFFF, 32'h8000_0000);
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            cmd[0] = tbl[i].cmd; din[0] = tbl[i].data; done[0] = tbl[i].done;
            @(negedge c_clk);
            chk_port($sformatf("tbl[%0d]", i), 0, tbl[i].prio, tbl[i].busy,
                     tbl[i].inv, 1'b0, tbl[i].d1, tbl[i].d2);
        end

        // All four ports issue together with their own codes and operands
        next_cycle();
        cmd[0] = 4'd1; cmd[1] = 4'd2; cmd[2] = 4'd5; cmd[3] = 4'd6;
        for (int p = 0; p < 4; p++) din[p] = 32'h100 * (p + 1) + 32'h1;
        next_cycle();
        for (int p = 0; p < 4; p++) din[p] = 32'h100 * (p + 1) + 32'h2;
        next_cycle();
        @(negedge c_clk);
        for (int p = 0; p < 4; p++)
            chk_port("all4 T+2", p, (p == 0) ? 4'd1 : (p == 1) ? 4'd2 : (p == 2) ? 4'd5 : 4'd6,
                     1, 0, 0, 32'h100 * (p + 1) + 32'h1, 32'h100 * (p + 1) + 32'h2);
        next_cycle();
        for (int p = 0; p < 4; p++) done[p] = 1'b1;
        next_cycle();
        @(negedge c_clk);
        for (int p = 0; p < 4; p++)
            chk($sformatf("all4 released p%0d busy", p + 1), {31'd0, busy[p]}, 32'd0);

        // Overrun on port 3: second command during WAIT is dropped
        next_cycle(); cmd[2] = 4'd6; din[2] = 32'hA;
        next_cycle(); din[2] = 32'hB;
        next_cycle();
        next_cycle(); cmd[2] = 4'd1; din[2] = 32'hC;
        @(negedge c_clk);
        chk("ovr p3 before", {31'd0, ovr[2]}, 32'd0);
        next_cycle(); done[2] = 1'b1;
        @(negedge c_clk);
        chk_port("ovr WAIT", 2, 4'd0, 1, 0, 1, 32'hA, 32'hB);
        next_cycle();
        @(negedge c_clk);
        chk_port("ovr after done", 2, 4'd0, 0, 0, 1, 32'hA, 32'hB);
        repeat (3) begin
            next_cycle();
            @(negedge c_clk);
            chk("ovr dropped no prio", {28'd0, prio[2]}, 32'd0);
        end

        // Port 4 parked in WAIT, then a half-cycle reset pulse
        next_cycle(); cmd[3] = 4'd2; din[3] = 32'h11;
        next_cycle(); din[3] = 32'h22;
        next_cycle();
        next_cycle();
        @(negedge c_clk);
        chk("rst p4 in WAIT busy", {31'd0, busy[3]}, 32'd1);
        @(posedge c_clk);
        #1 reset = 1'b0;
        #2;
        for (int p = 0; p < 4; p++) chk_port("async rst", p, 4'd0, 0, 0, 0, 32'd0, 32'd0);
        @(negedge c_clk);
        reset = 1'b1;
        next_cycle(); cmd[3] = 4'd1; din[3] = 32'h33;
        @(negedge c_clk);
        chk_port("post-rst T'", 3, 4'd0, 0, 0, 0, 32'd0, 32'd0);
        next_cycle(); din[3] = 32'h44;
        @(negedge c_clk);
        chk_port("post-rst T'+1", 3, 4'd0, 1, 0, 0, 32'h33, 32'd0);
        next_cycle();
        @(negedge c_clk);
        chk_port("post-rst T'+2", 3, 4'd1, 1, 0, 0, 32'h33, 32'h44);

        // Randomized traffic from a clean reset
        @(posedge c_clk);
        #1 reset = 1'b0;
        clr_inputs();
        @(negedge c_clk);
        reset = 1'b1;
        for (int p = 0; p < 4; p++) begin
            m_act[p] = 0; m_acc[p] = 0; m_lg[p] = 0; m_fin[p] = 0; m_cmd[p] = 4'd0;
            m_d1[p] = 32'd0; m_d2[p] = 32'd0; m_ovr[p] = 0;
        end
        for (int c = 0; c < 1500 && errors < 50; c++) begin
            next_cycle();
            for (int p = 0; p < 4; p++) begin
                cmd[p]  = ($urandom_range(3) == 0) ? 4'($urandom_range(15, 1)) : 4'd0;
                din[p]  = $urandom;
                done[p] = ($urandom_range(2) == 0);
            end
            @(negedge c_clk);
            for (int p = 0; p < 4; p++) begin
                bit   eb, ei;
                logic [3:0] ep;
                eb = m_act[p] && (c > m_acc[p]) && (m_fin[p] < 0 || c < m_fin[p]);
                ep = (m_act[p] && m_lg[p] && c == m_acc[p] + 2) ? m_cmd[p] : 4'd0;
                ei = m_act[p] && !m_lg[p] && (c == m_acc[p] + 2);
                chk_port($sformatf("rnd c%0d", c), p, ep, eb, ei, m_ovr[p], m_d1[p], m_d2[p]);
                if (!eb) begin
                    if (cmd[p] != 4'd0) begin
                        m_act[p] = 1; m_acc[p] = c; m_cmd[p] = cmd[p];
                        m_lg[p]  = legal(cmd[p]);
                        m_fin[p] = m_lg[p] ? -1 : c + 3;
                        m_d1[p]  = din[p];
                    end
                end else begin
                    if (cmd[p] != 4'd0) m_ovr[p] = 1;
                    if (c == m_acc[p] + 1) m_d2[p] = din[p];
                    if (m_lg[p] && m_fin[p] < 0 && c >= m_acc[p] + 3 && done[p])
                        m_fin[p] = c + 1;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
